// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing and hazard controller for the F/X/W pipeline.
// Tracks the W-stage instruction, produces PC/X enables, bubble insertion,
// operand forwarding selects, data-memory wait stalls and a timeout error.
// Optional performance counters (stall_cnt, flush_cnt) are compiled in when
// the macro PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst_x,
  input  logic              inst_x_valid,
  input  logic              br_taken_x,
  input  logic              imem_valid,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              x_en,
  output logic              x_bubble,
  output logic [31:0]       inst_w,
  output logic              w_valid,
  output logic              fwd1_sel,
  output logic              fwd2_sel,
  output logic              mem_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // The last stalled cycle allowed before giving up on the memory op.
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;
  logic [31:0]     inst_w_q, inst_w_d;
  logic            w_valid_q, w_valid_d;

  logic [6:0] opc_x;
  logic [6:0] opc_w;
  logic       has_rs1;
  logic       has_rs2;
  logic       has_rd;
  logic       w_mem;
  logic       stall;
  logic       adv;
  logic       fwd1_raw;
  logic       fwd2_raw;
  logic       unused_bits;

  assign opc_x = inst_x[6:0];
  assign opc_w = inst_w_q[6:0];

  // Operand usage of X and destination write of W, used for forwarding.
  always_comb begin
    has_rs1 = !((opc_x == OP_LUI) || (opc_x == OP_AUIPC) || (opc_x == OP_JAL));
    has_rs2 = (opc_x == OP_BRANCH) || (opc_x == OP_STORE) || (opc_x == OP_RTYPE);
    has_rd  = w_valid_q && (opc_w != OP_BRANCH) && (opc_w != OP_STORE) &&
              (inst_w_q[11:7] != 5'd0);
    w_mem   = w_valid_q && ((opc_w == OP_LOAD) || (opc_w == OP_STORE));
  end

  assign fwd1_raw = inst_x_valid & has_rs1 & has_rd & (inst_x[19:15] == inst_w_q[11:7]);
  assign fwd2_raw = inst_x_valid & has_rs2 & has_rd & (inst_x[24:20] == inst_w_q[11:7]);

  assign stall = w_mem & ~dmem_ready;
  assign adv   = ~stall & (state_q != ERR);

  // Only opcode and source fields of X matter to this block.
  assign unused_bits = ^{inst_x[31:25], inst_x[14:7]};

  // Next-state logic for the memory-wait FSM and the W-stage tracker.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      RUN: begin
        if (stall) begin
          state_d = MEM_WAIT;
          cnt_d   = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    inst_w_d  = adv ? inst_x : inst_w_q;
    w_valid_d = adv ? inst_x_valid : w_valid_q;
  end

  // State, timeout counter, error flag and W-stage tracker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
      inst_w_q  <= NOP_INST;
      w_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
      inst_w_q  <= inst_w_d;
      w_valid_q <= w_valid_d;
    end
  end

  // Pipeline control outputs; reset forces the idle values, ERR freezes
  // the front end with a bubble, a stall holds everything.
  always_comb begin
    pc_en    = imem_valid;
    x_en     = 1'b1;
    x_bubble = ~imem_valid | br_taken_x;
    fwd1_sel = fwd1_raw;
    fwd2_sel = fwd2_raw;
    if (!rst_n) begin
      pc_en    = 1'b1;
      x_en     = 1'b1;
      x_bubble = 1'b1;
      fwd1_sel = 1'b0;
      fwd2_sel = 1'b0;
    end else if (state_q == ERR) begin
      pc_en    = 1'b0;
      x_en     = 1'b0;
      x_bubble = 1'b1;
      fwd1_sel = 1'b0;
      fwd2_sel = 1'b0;
    end else if (stall) begin
      pc_en    = 1'b0;
      x_en     = 1'b0;
      x_bubble = 1'b0;
    end
  end

  assign inst_w  = inst_w_q;
  assign w_valid = w_valid_q;
  assign mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counter increments; both wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (state_q != ERR)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (adv && br_taken_x) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl.
// Each stimulus cycle pushes its hand-computed expected outputs; a monitor
// on the falling edge pops and compares against the DUT.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI_X5  = 32'h0010_0293;
  localparam logic [31:0] ADD_675  = 32'h0072_8333;
  localparam logic [31:0] ADD_657  = 32'h0053_8333;
  localparam logic [31:0] ADDI_X0  = 32'h0010_0013;
  localparam logic [31:0] ADD_100  = 32'h0000_00B3;
  localparam logic [31:0] SW_X5    = 32'h0050_22A3;
  localparam logic [31:0] LW_X5    = 32'h0000_2283;
  localparam logic [31:0] BEQ_8    = 32'h0000_0463;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_x;
  logic        inst_x_valid;
  logic        br_taken_x;
  logic        imem_valid;
  logic        dmem_ready;
  logic        pc_en;
  logic        x_en;
  logic        x_bubble;
  logic [31:0] inst_w;
  logic        w_valid;
  logic        fwd1_sel;
  logic        fwd2_sel;
  logic        mem_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  typedef struct {
    string       name;
    logic [38:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_x       (inst_x),
    .inst_x_valid (inst_x_valid),
    .br_taken_x   (br_taken_x),
    .imem_valid   (imem_valid),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .x_en         (x_en),
    .x_bubble     (x_bubble),
    .inst_w       (inst_w),
    .w_valid      (w_valid),
    .fwd1_sel     (fwd1_sel),
    .fwd2_sel     (fwd2_sel),
    .mem_err      (mem_err)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [38:0] ev(input logic pc, input logic xen, input logic bub,
                                     input logic [31:0] iw, input logic wv,
                                     input logic f1, input logic f2, input logic err);
    return {pc, xen, bub, iw, wv, f1, f2, err};
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic applyStimulus(input string name, input logic rst, input logic [31:0] ix,
                               input logic xv, input logic br, input logic iv,
                               input logic dr, input logic [38:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    inst_x       = ix;
    inst_x_valid = xv;
    br_taken_x   = br;
    imem_valid   = iv;
    dmem_ready   = dr;
    e.name = name;
    e.vec  = expv;
    exp_q.push_back(e);
  endtask

  // Compare one queued expectation against the current DUT outputs.
  task automatic checkOutput(input exp_t e);
    logic [38:0] act;
    act = {pc_en, x_en, x_bubble, inst_w, w_valid, fwd1_sel, fwd2_sel, mem_err};
    checks++;
    if (act !== e.vec) begin
      errors++;
      $display("[TB] FAIL %s: got pc_en=%b x_en=%b x_bubble=%b inst_w=%h w_valid=%b fwd1=%b fwd2=%b mem_err=%b, expected pc_en=%b x_en=%b x_bubble=%b inst_w=%h w_valid=%b fwd1=%b fwd2=%b mem_err=%b",
               e.name, act[38], act[37], act[36], act[35:4], act[3], act[2], act[1], act[0],
               e.vec[38], e.vec[37], e.vec[36], e.vec[35:4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
    end
  endtask

  // Monitor: pops one expectation per falling edge when one is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed stimulus sequence with hand-computed expectations.
  initial begin
    rst_n        = 1'b0;
    inst_x       = NOP;
    inst_x_valid = 1'b0;
    br_taken_x   = 1'b0;
    imem_valid   = 1'b1;
    dmem_ready   = 1'b0;

    applyStimulus("reset_a", 1'b0, NOP, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,1,1, NOP, 0, 0,0, 0));
    applyStimulus("reset_b", 1'b0, NOP, 1'b0, 1'b0, 1'b1, 1'b0, ev(1,1,1, NOP, 0, 0,0, 0));

    applyStimulus("run_first",   1'b1, ADDI_X5, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,0, NOP,     0, 0,0, 0));
    applyStimulus("fwd_rs1",     1'b1, ADD_675, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,0, ADDI_X5, 1, 1,0, 0));
    applyStimulus("no_fwd_imm",  1'b1, ADDI_X5, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,0, ADD_675, 1, 0,0, 0));
    applyStimulus("fwd_rs2",     1'b1, ADD_657, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,0, ADDI_X5, 1, 0,1, 0));
    applyStimulus("no_match",    1'b1, ADDI_X0, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,0, ADD_657, 1, 0,0, 0));
    applyStimulus("no_fwd_x0",   1'b1, ADD_100, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,0, ADDI_X0, 1, 0,0, 0));
    applyStimulus("pre_store",   1'b1, SW_X5,   1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,0, ADD_100, 1, 0,0, 0));
    applyStimulus("no_fwd_sw",   1'b1, ADD_657, 1'b1, 1'b0, 1'b1, 1'b1, ev(1,1,0, SW_X5,   1, 0,0, 0));
    applyStimulus("dready_idle", 1'b1, LW_X5,   1'b1, 1'b0, 1'b1, 1'b1, ev(1,1,0, ADD_657, 1, 0,0, 0));

    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("load_wait_%0d", i), 1'b1, ADD_675, 1'b1, 1'b0, 1'b1, 1'b0,
                    ev(0,0,0, LW_X5, 1, 1,0, 0));
    end
    applyStimulus("load_done",   1'b1, ADD_675, 1'b1, 1'b0, 1'b1, 1'b1, ev(1,1,0, LW_X5,   1, 1,0, 0));

    applyStimulus("redirect",    1'b1, BEQ_8,   1'b1, 1'b1, 1'b1, 1'b0, ev(1,1,1, ADD_675, 1, 0,0, 0));
    applyStimulus("branch_in_w", 1'b1, NOP,     1'b0, 1'b0, 1'b1, 1'b0, ev(1,1,0, BEQ_8,   1, 0,0, 0));
    applyStimulus("bubble_in_w", 1'b1, SW_X5,   1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,0, NOP,     0, 0,0, 0));
    applyStimulus("br_stalled",  1'b1, BEQ_8,   1'b1, 1'b1, 1'b1, 1'b0, ev(0,0,0, SW_X5,   1, 0,0, 0));
    applyStimulus("br_released", 1'b1, BEQ_8,   1'b1, 1'b1, 1'b1, 1'b1, ev(1,1,1, SW_X5,   1, 0,0, 0));
    applyStimulus("fetch_miss",  1'b1, NOP,     1'b0, 1'b0, 1'b0, 1'b0, ev(0,1,1, BEQ_8,   1, 0,0, 0));

    applyStimulus("to_issue",    1'b1, SW_X5,   1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,0, NOP,     0, 0,0, 0));
    for (int i = 1; i <= 16; i++) begin
      applyStimulus($sformatf("to_stall_%0d", i), 1'b1, ADD_657, 1'b1, 1'b0, 1'b1, 1'b0,
                    ev(0,0,0, SW_X5, 1, 0,0, 0));
    end
    applyStimulus("err_entered", 1'b1, ADD_657, 1'b1, 1'b0, 1'b1, 1'b0, ev(0,0,1, SW_X5,   1, 0,0, 1));
    applyStimulus("err_sticky",  1'b1, ADD_657, 1'b1, 1'b1, 1'b1, 1'b1, ev(0,0,1, SW_X5,   1, 0,0, 1));

    applyStimulus("err_reset_a", 1'b0, ADD_657, 1'b1, 1'b0, 1'b1, 1'b0, ev(1,1,1, NOP,     0, 0,0, 0));
    applyStimulus("err_reset_b", 1'b0, NOP,     1'b0, 1'b0, 1'b1, 1'b0, ev(1,1,1, NOP,     0, 0,0, 0));
    applyStimulus("after_reset", 1'b1, NOP,     1'b0, 1'b0, 1'b1, 1'b0, ev(1,1,0, NOP,     0, 0,0, 0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
